// File: rtl/boot_bus_arbiter.sv
// Shares the AHB-Lite memory port between the SPI boot loader (M0) and the core (M1),
// sequencing core bring-up and running a boot watchdog.
module boot_bus_arbiter #(
    parameter logic [23:0] BOOT_TIMEOUT = 24'd6000000,
    parameter logic [7:0]  RST_HOLD     = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ldr_done,
    input  logic [31:0] ldr_haddr,
    input  logic [1:0]  ldr_htrans,
    input  logic        ldr_hwrite,
    input  logic [2:0]  ldr_hsize,
    input  logic [31:0] ldr_hwdata,
    output logic        ldr_hready,
    input  logic [31:0] core_haddr,
    input  logic [1:0]  core_htrans,
    input  logic        core_hwrite,
    input  logic [2:0]  core_hsize,
    input  logic [31:0] core_hwdata,
    output logic        core_hready,
    output logic [31:0] core_hrdata,
    output logic [31:0] m_haddr,
    output logic [1:0]  m_htrans,
    output logic        m_hwrite,
    output logic [2:0]  m_hsize,
    output logic [31:0] m_hwdata,
    input  logic        m_hready,
    input  logic [31:0] m_hrdata,
    output logic        core_rst,
    output logic        boot_err,
    output logic        boot_busy
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_M0   = 2'd0,
        OWN_M1   = 2'd1,
        OWN_NONE = 2'd2
    } owner_e;

    localparam logic [7:0]  HOLD_LAST = (RST_HOLD == 8'd0) ? 8'd0 : RST_HOLD - 8'd1;
    localparam logic [23:0] WDOG_LAST = BOOT_TIMEOUT - 24'd1;
    localparam logic [23:0] WDOG_MAX  = 24'hFF_FFFF;

    state_e      state_q, state_d;
    owner_e      dph_owner_q, dph_owner_d;
    owner_e      aph_owner;
    logic        data_active_q, data_active_d;
    logic [23:0] wdog_q, wdog_d;
    logic [7:0]  hold_q, hold_d;
    logic        core_rst_q, core_rst_d;
    logic        boot_err_q, boot_err_d;
    logic        boot_busy_q, boot_busy_d;
    logic        wdog_expired;

    // Address-phase ownership follows the bring-up state; data phase lags by one accepted transfer
    always_comb begin
        aph_owner   = OWN_NONE;
        m_haddr     = core_haddr;
        m_hwrite    = core_hwrite;
        m_hsize     = core_hsize;
        m_htrans    = 2'b00;
        case (state_q)
            ST_BOOT: aph_owner = OWN_M0;
            ST_RUN:  aph_owner = OWN_M1;
            default: aph_owner = OWN_NONE;
        endcase
        if (aph_owner == OWN_M0) begin
            m_haddr  = ldr_haddr;
            m_htrans = ldr_htrans;
            m_hwrite = ldr_hwrite;
            m_hsize  = ldr_hsize;
        end else if (aph_owner == OWN_M1) begin
            m_haddr  = core_haddr;
            m_htrans = core_htrans;
            m_hwrite = core_hwrite;
            m_hsize  = core_hsize;
        end
        m_hwdata    = (dph_owner_q == OWN_M1) ? core_hwdata : ldr_hwdata;
        ldr_hready  = (aph_owner == OWN_M0 || dph_owner_q == OWN_M0) ? m_hready : 1'b1;
        core_hready = (state_q == ST_RUN) ? m_hready : 1'b0;
        core_hrdata = m_hrdata;
    end

    assign wdog_expired = (BOOT_TIMEOUT != 24'd0) && (wdog_q == WDOG_LAST);

    // Bring-up sequencer: next state, counters and registered status
    always_comb begin
        state_d       = state_q;
        dph_owner_d   = dph_owner_q;
        data_active_d = data_active_q;
        wdog_d        = wdog_q;
        hold_d        = hold_q;
        boot_err_d    = boot_err_q;

        if (m_hready) begin
            dph_owner_d   = aph_owner;
            data_active_d = m_htrans[1];
        end

        case (state_q)
            ST_BOOT: begin
                if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 24'd1;
                if (ldr_done) begin
                    state_d = ST_DRAIN;
                end else if (wdog_expired) begin
                    boot_err_d = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!data_active_q && m_hready) begin
                    hold_d  = 8'd0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (hold_q == HOLD_LAST) state_d = ST_RUN;
                else                     hold_d  = hold_q + 8'd1;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase

        core_rst_d  = (state_d != ST_RUN);
        boot_busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            dph_owner_q   <= OWN_M0;
            data_active_q <= 1'b0;
            wdog_q        <= 24'd0;
            hold_q        <= 8'd0;
            core_rst_q    <= 1'b1;
            boot_err_q    <= 1'b0;
            boot_busy_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            dph_owner_q   <= dph_owner_d;
            data_active_q <= data_active_d;
            wdog_q        <= wdog_d;
            hold_q        <= hold_d;
            core_rst_q    <= core_rst_d;
            boot_err_q    <= boot_err_d;
            boot_busy_q   <= boot_busy_d;
        end
    end

    assign core_rst  = core_rst_q;
    assign boot_err  = boot_err_q;
    assign boot_busy = boot_busy_q;

endmodule

// File: tb/tb_boot_bus_arbiter.sv
// Bench for boot_bus_arbiter: vector table, directed bring-up sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_boot_bus_arbiter;

    localparam logic [23:0] TO   = 24'd100;
    localparam logic [7:0]  HOLD = 8'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ldr_done = 1'b0;
    logic [31:0] ldr_haddr = '0;
    logic [1:0]  ldr_htrans = '0;
    logic        ldr_hwrite = 1'b0;
    logic [2:0]  ldr_hsize = '0;
    logic [31:0] ldr_hwdata = '0;
    logic        ldr_hready;
    logic [31:0] core_haddr = '0;
    logic [1:0]  core_htrans = '0;
    logic        core_hwrite = 1'b0;
    logic [2:0]  core_hsize = '0;
    logic [31:0] core_hwdata = '0;
    logic        core_hready;
    logic [31:0] core_hrdata;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        m_hready = 1'b1;
    logic [31:0] m_hrdata = '0;
    logic        core_rst;
    logic        boot_err;
    logic        boot_busy;

    always #5 clk = ~clk;

    boot_bus_arbiter #(.BOOT_TIMEOUT(TO), .RST_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .ldr_done(ldr_done),
        .ldr_haddr(ldr_haddr), .ldr_htrans(ldr_htrans), .ldr_hwrite(ldr_hwrite),
        .ldr_hsize(ldr_hsize), .ldr_hwdata(ldr_hwdata), .ldr_hready(ldr_hready),
        .core_haddr(core_haddr), .core_htrans(core_htrans), .core_hwrite(core_hwrite),
        .core_hsize(core_hsize), .core_hwdata(core_hwdata), .core_hready(core_hready),
        .core_hrdata(core_hrdata),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hrdata(m_hrdata),
        .core_rst(core_rst), .boot_err(boot_err), .boot_busy(boot_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=boot 1=drain 2=release 3=run; owner 0=loader 1=core 2=none
    int md_phase = 0;
    int md_boot_cycles = 0;
    int md_hold = 0;
    bit md_dact = 1'b0;
    int md_down = 0;
    bit md_err = 1'b0;
    bit md_rst = 1'b1;

    function automatic int addr_owner();
        if (md_phase == 0) return 0;
        if (md_phase == 3) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin : model
        int ao;
        int nxt;
        int hold_len;
        bit busy_trans;
        if (reset) begin
            md_phase = 0; md_boot_cycles = 0; md_hold = 0;
            md_dact = 1'b0; md_down = 0; md_err = 1'b0; md_rst = 1'b1;
        end else begin
            ao = addr_owner();
            busy_trans = (ao == 0) ? ldr_htrans[1] : (ao == 1) ? core_htrans[1] : 1'b0;
            hold_len = (HOLD == 8'd0) ? 1 : int'(HOLD);
            nxt = md_phase;
            case (md_phase)
                0: begin
                    if (ldr_done) nxt = 1;
                    else if (TO != 24'd0 && md_boot_cycles + 1 == int'(TO)) begin
                        md_err = 1'b1;
                        nxt = 1;
                    end
                    if (md_boot_cycles < 24'hFF_FFFF) md_boot_cycles++;
                end
                1: if (!md_dact && m_hready) begin md_hold = 0; nxt = 2; end
                2: if (md_hold + 1 >= hold_len) nxt = 3; else md_hold++;
                default: nxt = 3;
            endcase
            if (m_hready) begin
                md_down = ao;
                md_dact = busy_trans;
            end
            md_phase = nxt;
            md_rst = (nxt != 3);
        end
    end

    // Compare every output against the model for the inputs currently applied
    task automatic chk_all();
        int ao;
        logic [1:0] exp_t;
        #1;
        ao = addr_owner();
        exp_t = (ao == 0) ? ldr_htrans : (ao == 1) ? core_htrans : 2'b00;
        check("m_htrans", 32'(m_htrans), 32'(exp_t));
        if (ao != 2) begin
            check("m_haddr",  m_haddr, (ao == 0) ? ldr_haddr : core_haddr);
            check("m_hwrite", 32'(m_hwrite), 32'((ao == 0) ? ldr_hwrite : core_hwrite));
            check("m_hsize",  32'(m_hsize), 32'((ao == 0) ? ldr_hsize : core_hsize));
        end
        if (md_down != 2)
            check("m_hwdata", m_hwdata, (md_down == 0) ? ldr_hwdata : core_hwdata);
        check("ldr_hready", 32'(ldr_hready),
              32'((ao == 0 || md_down == 0) ? m_hready : 1'b1));
        check("core_hready", 32'(core_hready), 32'((md_phase == 3) ? m_hready : 1'b0));
        check("core_hrdata", core_hrdata, m_hrdata);
        check("core_rst",  32'(core_rst),  32'(md_rst));
        check("boot_err",  32'(boot_err),  32'(md_err));
        check("boot_busy", 32'(boot_busy), 32'(md_phase != 3));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ldr_done = 1'b0; ldr_htrans = 2'b00; core_htrans = 2'b00; m_hready = 1'b1;
    endtask

    // Counts cycles with core_rst high before it drops (bounded)
    task automatic count_rst_cycles(output int cnt);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            chk_all();
            if (!core_rst) break;
            check("hold_idle", 32'(m_htrans), 32'd0);
            cnt++;
            tick();
        end
    endtask

    typedef struct {
        logic [1:0]  lt;
        logic [31:0] la;
        logic [1:0]  ct;
        logic [31:0] ca;
        logic        rdy;
        logic [1:0]  exp_mt;
        logic [31:0] exp_ma;
        logic        exp_lr;
        logic        exp_cr;
    } vec_t;

    vec_t vt[6];
    int   cnt;

    initial begin
        vt[0] = '{2'd2, 32'h100, 2'd2, 32'h900, 1'b1, 2'd2, 32'h100, 1'b1, 1'b0};
        vt[1] = '{2'd0, 32'h104, 2'd2, 32'h904, 1'b1, 2'd0, 32'h104, 1'b1, 1'b0};
        vt[2] = '{2'd3, 32'h108, 2'd1, 32'h908, 1'b0, 2'd3, 32'h108, 1'b0, 1'b0};
        vt[3] = '{2'd1, 32'h10C, 2'd0, 32'h90C, 1'b0, 2'd1, 32'h10C, 1'b0, 1'b0};
        vt[4] = '{2'd2, 32'h110, 2'd3, 32'h910, 1'b1, 2'd2, 32'h110, 1'b1, 1'b0};
        vt[5] = '{2'd0, 32'h0,   2'd2, 32'hFFC, 1'b0, 2'd0, 32'h0,   1'b0, 1'b0};

        reset = 1'b1;
        tick(); tick();
        check("reset_core_rst", 32'(core_rst), 32'd1);
        check("reset_boot_err", 32'(boot_err), 32'd0);
        check("reset_boot_busy", 32'(boot_busy), 32'd1);
        check("reset_core_hready", 32'(core_hready), 32'd0);
        reset = 1'b0;

        // Boot-state muxing from the vector table
        for (int i = 0; i < 6; i++) begin
            ldr_htrans = vt[i].lt; ldr_haddr = vt[i].la;
            core_htrans = vt[i].ct; core_haddr = vt[i].ca; m_hready = vt[i].rdy;
            #1;
            check("vec_m_htrans", 32'(m_htrans), 32'(vt[i].exp_mt));
            check("vec_m_haddr", m_haddr, vt[i].exp_ma);
            check("vec_ldr_hready", 32'(ldr_hready), 32'(vt[i].exp_lr));
            check("vec_core_hready", 32'(core_hready), 32'(vt[i].exp_cr));
            tick();
        end
        idle_inputs();
        chk_all(); tick();

        // Loader write: address phase then data phase
        ldr_htrans = 2'd2; ldr_haddr = 32'h200; ldr_hwrite = 1'b1; ldr_hsize = 3'd2;
        chk_all();
        check("wr_addr", m_haddr, 32'h200);
        tick();
        ldr_htrans = 2'd0; ldr_hwdata = 32'hDEAD_BEEF;
        chk_all();
        check("wr_data", m_hwdata, 32'hDEAD_BEEF);
        check("wr_core_rst", 32'(core_rst), 32'd1);
        check("wr_core_hready", 32'(core_hready), 32'd0);
        tick();

        // ldr_done with a write in flight and a 3-cycle slave stall
        ldr_htrans = 2'd2; ldr_haddr = 32'h300; ldr_done = 1'b1;
        chk_all();
        check("done_fwd", m_haddr, 32'h300);
        tick();
        ldr_done = 1'b0; ldr_hwdata = 32'hCAFE_F00D; m_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_all();
            check("drain_idle", 32'(m_htrans), 32'd0);
            check("drain_ldr_hready", 32'(ldr_hready), 32'd0);
            check("drain_core_rst", 32'(core_rst), 32'd1);
            tick();
        end
        m_hready = 1'b1;
        chk_all();
        check("drain_wdata", m_hwdata, 32'hCAFE_F00D);
        tick();
        chk_all(); tick();
        count_rst_cycles(cnt);
        check("hold_cycles", 32'(cnt), 32'd16);
        check("run_core_rst", 32'(core_rst), 32'd0);
        check("run_boot_busy", 32'(boot_busy), 32'd0);
        check("run_boot_err", 32'(boot_err), 32'd0);

        // Core read in RUN; loader inputs ignored
        core_htrans = 2'd2; core_haddr = 32'h204; core_hwrite = 1'b0; ldr_haddr = 32'hBAD0;
        chk_all();
        check("run_addr", m_haddr, 32'h204);
        check("run_trans", 32'(m_htrans), 32'd2);
        tick();
        core_htrans = 2'd0; m_hrdata = 32'h1234_5678; m_hready = 1'b0;
        chk_all();
        check("run_hrdata", core_hrdata, 32'h1234_5678);
        check("run_hready_lo", 32'(core_hready), 32'd0);
        check("run_ldr_hready", 32'(ldr_hready), 32'd1);
        tick();
        m_hready = 1'b1;
        chk_all();
        check("run_hready_hi", 32'(core_hready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            ldr_htrans = 2'(i);
            chk_all();
            check("run_ignore_ldr", 32'(m_htrans), 32'd0);
            tick();
        end
        idle_inputs();

        // Watchdog timeout
        reset = 1'b1; tick(); reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            chk_all();
            if (boot_err) break;
            tick();
            cnt++;
        end
        check("timeout_cycle", 32'(cnt), 32'd100);
        count_rst_cycles(cnt);
        check("timeout_release", 32'(cnt), 32'd17);
        check("timeout_err_sticky", 32'(boot_err), 32'd1);
        check("timeout_run", 32'(boot_busy), 32'd0);

        // ldr_done coinciding with watchdog expiry
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 99; i++) begin chk_all(); tick(); end
        ldr_done = 1'b1;
        chk_all(); tick();
        ldr_done = 1'b0;
        check("coincide_err", 32'(boot_err), 32'd0);
        count_rst_cycles(cnt);
        check("coincide_release", 32'(cnt), 32'd17);
        check("coincide_err_run", 32'(boot_err), 32'd0);

        // Reset in RELEASE at hold count 5
        reset = 1'b1; tick(); reset = 1'b0;
        ldr_done = 1'b1; chk_all(); tick();
        ldr_done = 1'b0; chk_all(); tick();
        for (int i = 0; i < 5; i++) begin chk_all(); tick(); end
        ldr_htrans = 2'd2; ldr_haddr = 32'h400;
        chk_all();
        check("rel_pre_idle", 32'(m_htrans), 32'd0);
        check("rel_pre_rst", 32'(core_rst), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all();
        check("rel_rst_core_rst", 32'(core_rst), 32'd1);
        check("rel_rst_busy", 32'(boot_busy), 32'd1);
        check("rel_rst_trans", 32'(m_htrans), 32'd2);
        check("rel_rst_addr", m_haddr, 32'h400);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ldr_done    = ($urandom_range(0, 29) == 0);
            ldr_htrans  = 2'($urandom_range(0, 3));
            core_htrans = 2'($urandom_range(0, 3));
            ldr_haddr   = $urandom;
            core_haddr  = $urandom;
            ldr_hwdata  = $urandom;
            core_hwdata = $urandom;
            m_hrdata    = $urandom;
            ldr_hwrite  = 1'($urandom_range(0, 1));
            core_hwrite = 1'($urandom_range(0, 1));
            ldr_hsize   = 3'($urandom_range(0, 7));
            core_hsize  = 3'($urandom_range(0, 7));
            m_hready    = ($urandom_range(0, 3) != 0);
            chk_all();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
